// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings,
// default bus widths and the arbiter state encoding.
package sdram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int BANK_W_DEF = 2;

  // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_MRS       = 4'b0000;

  // Arbiter states
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t ST_INIT    = 3'd0;
  localparam arb_state_t ST_ARBIT   = 3'd1;
  localparam arb_state_t ST_REFRESH = 3'd2;
  localparam arb_state_t ST_WRITE   = 3'd3;
  localparam arb_state_t ST_READ    = 3'd4;

endpackage

// File: rtl/sdram_grant_watchdog.sv
// Grant watchdog: counts cycles spent in a grant state and forces the
// grant back to arbitration if the owner never pulses its end signal.
module sdram_grant_watchdog #(
  parameter int GRANT_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_grant,
  input  logic owner_end,
  output logic expire,
  output logic grant_timeout
);

  localparam int CW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(GRANT_TIMEOUT - 1);

  logic [CW-1:0] count;

  // A normal end pulse on the last allowed cycle wins over the timeout.
  assign expire = in_grant && (count == LIMIT) && !owner_end;

  // Counter sits at zero outside grants so every grant starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!in_grant) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // One-cycle pulse coincident with the revoked ack falling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_timeout <= 1'b0;
    end else begin
      grant_timeout <= expire;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// Central SDRAM command arbiter. Grants the bus to one of refresh, write or
// read (refresh first, write/read alternating) with a req/ack/end handshake,
// and muxes the owner's command, address and bank onto the SDRAM bus.
// Handshake: a stage holds req high; ack rises the cycle after req is seen in
// ARBIT and stays high while the stage owns the bus; a one-cycle end pulse
// from the owner releases the bus on the next edge, and at least one NOP
// cycle separates consecutive grants.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 1000,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int BANK_W        = BANK_W_DEF
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              refresh_req,
  output logic              refresh_ack,
  input  logic              refresh_end,
  input  logic [3:0]        refresh_cmd,
  input  logic [ADDR_W-1:0] refresh_addr,
  input  logic              write_req,
  output logic              write_ack,
  input  logic              write_end,
  input  logic [3:0]        write_cmd,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [BANK_W-1:0] write_bank,
  input  logic              read_req,
  output logic              read_ack,
  input  logic              read_end,
  input  logic [3:0]        read_cmd,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [BANK_W-1:0] read_bank,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank_addr,
  output logic              grant_timeout,
  output logic [2:0]        state_dbg
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last_was_write;
  logic       in_grant;
  logic       owner_end;
  logic       expire;

  assign state_dbg = state;
  assign in_grant  = (state == ST_REFRESH) || (state == ST_WRITE) || (state == ST_READ);

  // Only the current owner's end pulse is honoured.
  always_comb begin
    owner_end = 1'b0;
    case (state)
      ST_REFRESH: owner_end = refresh_end;
      ST_WRITE:   owner_end = write_end;
      ST_READ:    owner_end = read_end;
      default:    owner_end = 1'b0;
    endcase
  end

  sdram_grant_watchdog #(
    .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) u_watchdog (
    .clk          (sysclk_100M),
    .rst_n        (rst_n),
    .in_grant     (in_grant),
    .owner_end    (owner_end),
    .expire       (expire),
    .grant_timeout(grant_timeout)
  );

  // Next-state: refresh wins, then write/read alternate when both pend.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (init_done) state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (refresh_req)              state_nxt = ST_REFRESH;
        else if (write_req && read_req) state_nxt = last_was_write ? ST_READ : ST_WRITE;
        else if (write_req)           state_nxt = ST_WRITE;
        else if (read_req)            state_nxt = ST_READ;
      end
      ST_REFRESH, ST_WRITE, ST_READ: begin
        if (owner_end || expire) state_nxt = ST_ARBIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // State, registered acks (mirroring the grant state) and fairness flag.
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_INIT;
      refresh_ack    <= 1'b0;
      write_ack      <= 1'b0;
      read_ack       <= 1'b0;
      last_was_write <= 1'b0;
    end else begin
      state       <= state_nxt;
      refresh_ack <= (state_nxt == ST_REFRESH);
      write_ack   <= (state_nxt == ST_WRITE);
      read_ack    <= (state_nxt == ST_READ);
      if (state_nxt == ST_WRITE && state != ST_WRITE) begin
        last_was_write <= 1'b1;
      end else if (state_nxt == ST_READ && state != ST_READ) begin
        last_was_write <= 1'b0;
      end
    end
  end

  // Clock enable comes up on the first edge out of reset and stays up.
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      sdram_cke <= 1'b0;
    end else begin
      sdram_cke <= 1'b1;
    end
  end

  // Bus mux straight from the registered state: owner commands pass through
  // with no added latency.
  always_comb begin
    sdram_cmd       = CMD_NOP;
    sdram_addr      = '0;
    sdram_bank_addr = '0;
    case (state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_REFRESH: begin
        sdram_cmd  = refresh_cmd;
        sdram_addr = refresh_addr;
      end
      ST_WRITE: begin
        sdram_cmd       = write_cmd;
        sdram_addr      = write_addr;
        sdram_bank_addr = write_bank;
      end
      ST_READ: begin
        sdram_cmd       = read_cmd;
        sdram_addr      = read_addr;
        sdram_bank_addr = read_bank;
      end
      default: begin
        sdram_cmd       = CMD_NOP;
        sdram_addr      = '0;
        sdram_bank_addr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed init/priority/refresh/watchdog/reset
// sequences plus randomized request batches.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int GT = 16;
  localparam int AW = 13;
  localparam int BW = 2;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic          refresh_req, refresh_ack, refresh_end;
  logic [3:0]    refresh_cmd;
  logic [AW-1:0] refresh_addr;
  logic          write_req, write_ack, write_end;
  logic [3:0]    write_cmd;
  logic [AW-1:0] write_addr;
  logic [BW-1:0] write_bank;
  logic          read_req, read_ack, read_end;
  logic [3:0]    read_cmd;
  logic [AW-1:0] read_addr;
  logic [BW-1:0] read_bank;
  logic          sdram_cke;
  logic [3:0]    sdram_cmd;
  logic [AW-1:0] sdram_addr;
  logic [BW-1:0] sdram_bank_addr;
  logic          grant_timeout;
  logic [2:0]    state_dbg;

  sdram_arbit #(
    .GRANT_TIMEOUT(GT),
    .ADDR_W       (AW),
    .BANK_W       (BW)
  ) dut (
    .sysclk_100M    (clk),
    .rst_n          (rst_n),
    .init_done      (init_done),
    .init_cmd       (init_cmd),
    .init_addr      (init_addr),
    .refresh_req    (refresh_req),
    .refresh_ack    (refresh_ack),
    .refresh_end    (refresh_end),
    .refresh_cmd    (refresh_cmd),
    .refresh_addr   (refresh_addr),
    .write_req      (write_req),
    .write_ack      (write_ack),
    .write_end      (write_end),
    .write_cmd      (write_cmd),
    .write_addr     (write_addr),
    .write_bank     (write_bank),
    .read_req       (read_req),
    .read_ack       (read_ack),
    .read_end       (read_end),
    .read_cmd       (read_cmd),
    .read_addr      (read_addr),
    .read_bank      (read_bank),
    .sdram_cke      (sdram_cke),
    .sdram_cmd      (sdram_cmd),
    .sdram_addr     (sdram_addr),
    .sdram_bank_addr(sdram_bank_addr),
    .grant_timeout  (grant_timeout),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [1:0] exp_q[$];      // expected grant order: 0 refresh, 1 write, 2 read
  bit         init_phase;    // DUT is expected to be in its init pass-through
  bit         model_last_wr; // reference fairness memory

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [2:0] prev_acks;
    logic [2:0] acks;
    logic [2:0] rise;
    logic [3:0] e_cmd;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_bank;
    int id;
    prev_acks = '0;
    forever begin
      @(negedge clk);
      acks = {read_ack, write_ack, refresh_ack};
      check("ack_onehot", ($countones(acks) <= 1), 1);
      e_bank = '0;
      if (init_phase) begin
        e_cmd = init_cmd; e_addr = init_addr;
      end else if (refresh_ack) begin
        e_cmd = refresh_cmd; e_addr = refresh_addr;
      end else if (write_ack) begin
        e_cmd = write_cmd; e_addr = write_addr; e_bank = write_bank;
      end else if (read_ack) begin
        e_cmd = read_cmd; e_addr = read_addr; e_bank = read_bank;
      end else begin
        e_cmd = CMD_NOP; e_addr = '0;
      end
      check("bus_cmd", sdram_cmd, e_cmd);
      check("bus_addr", sdram_addr, e_addr);
      check("bus_bank", sdram_bank_addr, e_bank);
      rise = acks & ~prev_acks;
      if (rise != 0) begin
        check("grant_gap", prev_acks, 0);
        id = rise[0] ? 0 : (rise[1] ? 1 : 2);
        check("grant_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("grant_owner", id, exp_q.pop_front());
      end
      prev_acks = acks;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    refresh_cmd  = 4'($urandom_range(0, 15));
    refresh_addr = AW'($urandom);
    write_cmd    = 4'($urandom_range(0, 15));
    write_addr   = AW'($urandom);
    write_bank   = BW'($urandom_range(0, 3));
    read_cmd     = 4'($urandom_range(0, 15));
    read_addr    = AW'($urandom);
    read_bank    = BW'($urandom_range(0, 3));
    init_cmd     = 4'($urandom_range(0, 15));
    init_addr    = AW'($urandom);
  endtask

  task automatic set_req(input int owner, input bit v);
    case (owner)
      0: refresh_req = v;
      1: write_req   = v;
      default: read_req = v;
    endcase
  endtask

  task automatic do_init();
    init_done = 1'b0;
    init_cmd  = 4'b0010;
    init_addr = AW'($urandom);
    repeat (20) tick();
    check("init_state", state_dbg, ST_INIT);
    init_done = 1'b1;
    tick();
    init_phase = 1'b0;
    check("init_to_arbit", state_dbg, ST_ARBIT);
    check("init_nop", sdram_cmd, CMD_NOP);
    init_done = 1'b0;
    init_cmd  = 4'b0000;
  endtask

  // Waits for any ack, returning the owner and how many edges it took.
  task automatic wait_ack(output int owner, output int cyc);
    owner = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (refresh_ack || write_ack || read_ack) begin
        owner = refresh_ack ? 0 : (write_ack ? 1 : 2);
        cyc = i;
        return;
      end
    end
    cyc = 40;
    n_cmp++;
    n_fail++;
    $display("FAIL grant_wait: no ack within 40 cycles at %0t", $time);
  endtask

  // Owner drives traffic for 'hold' cycles, non-owners pulse stray ends,
  // and the owner ends on the last cycle.
  task automatic serve_one(input int owner, input int hold);
    for (int c = 0; c < hold; c++) begin
      scramble();
      refresh_end = (owner == 0) ? (c == hold - 1) : 1'($urandom_range(0, 1));
      write_end   = (owner == 1) ? (c == hold - 1) : 1'($urandom_range(0, 1));
      read_end    = (owner == 2) ? (c == hold - 1) : 1'($urandom_range(0, 1));
      if (c == hold - 1) set_req(owner, 1'b0);
      tick();
    end
    refresh_end = 1'b0;
    write_end   = 1'b0;
    read_end    = 1'b0;
    check("ack_drop", {read_ack, write_ack, refresh_ack}, 0);
  endtask

  // Reference arbitration: from a set of pending requests, list the grant
  // order implied by "refresh first, then write/read alternating".
  task automatic model_push(input bit r, input bit w, input bit rd);
    bit pr, pw, pd;
    pr = r; pw = w; pd = rd;
    while (pr || pw || pd) begin
      int pick;
      if (pr) pick = 0;
      else if (pw && pd) pick = model_last_wr ? 2 : 1;
      else if (pw) pick = 1;
      else pick = 2;
      exp_q.push_back(2'(pick));
      case (pick)
        0: pr = 1'b0;
        1: begin pw = 1'b0; model_last_wr = 1'b1; end
        default: begin pd = 1'b0; model_last_wr = 1'b0; end
      endcase
    end
  endtask

  task automatic run_batch(input bit r, input bit w, input bit rd);
    int n, owner, cyc;
    n = int'(r) + int'(w) + int'(rd);
    model_push(r, w, rd);
    refresh_req = r;
    write_req   = w;
    read_req    = rd;
    if (n == 0) repeat (3) tick();
    for (int i = 0; i < n; i++) begin
      wait_ack(owner, cyc);
      if (owner < 0) begin
        refresh_req = 1'b0; write_req = 1'b0; read_req = 1'b0;
        exp_q.delete();
        return;
      end
      check("grant_latency", cyc, 1);
      serve_one(owner, $urandom_range(1, 6));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int owner, cyc;
    rst_n = 1'b0;
    init_phase = 1'b1;
    model_last_wr = 1'b0;
    init_done = 1'b0;
    init_cmd = 4'b0010;
    init_addr = '0;
    refresh_req = 0; refresh_end = 0; refresh_cmd = 0; refresh_addr = 0;
    write_req = 0; write_end = 0; write_cmd = 0; write_addr = 0; write_bank = 0;
    read_req = 0; read_end = 0; read_cmd = 0; read_addr = 0; read_bank = 0;
    #2;
    check("rst_acks", {read_ack, write_ack, refresh_ack}, 0);
    check("rst_cke", sdram_cke, 0);
    check("rst_timeout", grant_timeout, 0);
    check("rst_state", state_dbg, ST_INIT);
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();
    check("cke_up", sdram_cke, 1);

    do_init();

    // single read, then priority among all three
    run_batch(1'b0, 1'b0, 1'b1);
    run_batch(1'b1, 1'b1, 1'b1);
    run_batch(1'b0, 1'b1, 1'b1);

    // refresh raised while read owns the bus; read ends early and re-requests
    read_req = 1'b1;
    exp_q.push_back(2'd2);
    model_last_wr = 1'b0;
    wait_ack(owner, cyc);
    check("rd_latency", cyc, 1);
    refresh_req = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    for (int c = 0; c < 4; c++) begin
      scramble();
      read_end = (c == 3);
      tick();
    end
    read_end = 1'b0;
    check("rd_early_drop", read_ack, 0);
    wait_ack(owner, cyc);
    check("refresh_after_rd_latency", cyc, 1);
    if (owner >= 0) serve_one(owner, 2);
    wait_ack(owner, cyc);
    check("rd_again_latency", cyc, 1);
    if (owner >= 0) serve_one(owner, 3);

    // watchdog: write never ends
    write_req = 1'b1;
    exp_q.push_back(2'd1);
    model_last_wr = 1'b1;
    wait_ack(owner, cyc);
    for (int i = 0; i < GT - 1; i++) begin
      tick();
      check("wd_hold_ack", write_ack, 1);
      check("wd_hold_to", grant_timeout, 0);
    end
    tick();
    check("wd_revoke_ack", write_ack, 0);
    check("wd_pulse", grant_timeout, 1);
    write_req = 1'b0;
    tick();
    check("wd_pulse_once", grant_timeout, 0);

    // write ends on the last allowed cycle: no timeout
    write_req = 1'b1;
    exp_q.push_back(2'd1);
    model_last_wr = 1'b1;
    wait_ack(owner, cyc);
    for (int i = 0; i < GT - 1; i++) begin
      tick();
      check("wd_edge_hold", write_ack, 1);
    end
    write_end = 1'b1;
    write_req = 1'b0;
    tick();
    write_end = 1'b0;
    check("wd_edge_drop", write_ack, 0);
    check("wd_edge_no_to", grant_timeout, 0);
    tick();
    check("wd_edge_no_to2", grant_timeout, 0);

    // last grant was a write: contention should go to read first
    run_batch(1'b0, 1'b1, 1'b1);

    // randomized request batches
    for (int k = 0; k < 30; k++) begin
      run_batch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a write grant
    write_req = 1'b1;
    exp_q.push_back(2'd1);
    wait_ack(owner, cyc);
    tick();
    #2;
    rst_n = 1'b0;
    init_phase = 1'b1;
    write_req = 1'b0;
    model_last_wr = 1'b0;
    init_cmd = 4'b0010;
    #1;
    check("arst_ack", write_ack, 0);
    check("arst_cke", sdram_cke, 0);
    check("arst_state", state_dbg, ST_INIT);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    check("arst_cke_hold", sdram_cke, 0);
    tick();
    check("arst_cke_up", sdram_cke, 1);
    check("arst_init", state_dbg, ST_INIT);
    do_init();
    run_batch(1'b0, 1'b1, 1'b1);

    repeat (2) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

endmodule
